// File: rtl/req_arbiter_2to1_pkg.sv
// Shared constants for the 2:1 request arbiter.
//   ADDRESS_WIDTH : default request address width
//   ID_WIDTH      : default request id width (top nibble is the source tag,
//                   carried through untouched)
//   FLUSH_DEPTH   : number of flushes the flush queue can hold within a cycle
package req_arbiter_2to1_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 8;
  localparam int FLUSH_DEPTH   = 2;

endpackage

// File: rtl/req_arbiter_2to1_flush_fifo2.sv
// flush_fifo2: two-entry flush queue with two ordered pushes and one pop per cycle.
//   clk, reset            : clock, asynchronous active-low reset
//   push_1 / push_id_1    : first push of the cycle (channel 1 flush)
//   push_2 / push_id_2    : second push of the cycle (channel 2 flush)
//   pop_valid / pop_id    : registered head, a one-cycle pulse per forwarded flush;
//                           pop_id is zero when nothing is forwarded
//   overflow              : sticky, set when a push found the queue full
module flush_fifo2
  import req_arbiter_2to1_pkg::*;
#(
  parameter int W = ID_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_1,
  input  logic [W-1:0] push_id_1,
  input  logic         push_2,
  input  logic [W-1:0] push_id_2,
  output logic         pop_valid,
  output logic [W-1:0] pop_id,
  output logic         overflow
);

  localparam logic [1:0] DEPTH = 2'(FLUSH_DEPTH);

  // The head is popped on every edge, so at most one entry survives an edge.
  // The depth of two bounds what is present during a cycle: the surviving
  // entry plus this cycle's accepted arrivals.
  logic         held_valid;
  logic [W-1:0] held_id;

  logic         acc_1;
  logic         acc_2;
  logic         drop;
  logic [1:0]   cnt_0;
  logic [1:0]   cnt_1;
  logic [1:0]   cnt_2;
  logic [W-1:0] first_arr;
  logic [W-1:0] slot_0;
  logic [W-1:0] slot_1;

  always_comb begin
    cnt_0     = {1'b0, held_valid};
    acc_1     = push_1 & (cnt_0 < DEPTH);
    cnt_1     = cnt_0 + {1'b0, acc_1};
    acc_2     = push_2 & (cnt_1 < DEPTH);
    cnt_2     = cnt_1 + {1'b0, acc_2};
    drop      = (push_1 & ~acc_1) | (push_2 & ~acc_2);
    // Oldest first: surviving entry, then channel 1 arrival, then channel 2.
    first_arr = acc_1 ? push_id_1 : push_id_2;
    slot_0    = held_valid ? held_id : first_arr;
    slot_1    = held_valid ? first_arr : push_id_2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
      held_id    <= '0;
      pop_valid  <= 1'b0;
      pop_id     <= '0;
      overflow   <= 1'b0;
    end else begin
      pop_valid  <= (cnt_2 != 2'd0);
      pop_id     <= (cnt_2 != 2'd0) ? slot_0 : '0;
      held_valid <= (cnt_2 == 2'd2);
      if (cnt_2 == 2'd2) begin
        held_id <= slot_1;
      end
      overflow   <= overflow | drop;
    end
  end

endmodule

// File: rtl/req_arbiter_2to1.sv
// req_arbiter_2to1: shares one downstream request pipeline between two producers.
// Each producer feeds a one-entry hold register; a round-robin grant moves one
// hold per cycle into a registered output stage. Flush-by-id kills matching
// held / in-flight requests in the same cycle and is forwarded downstream
// through a small flush queue that ignores downstream stall.
//   clk, reset                       : clock, asynchronous active-low reset
//   in_valid_k/in_address_k/in_id_k  : request from producer k (k = 1, 2)
//   out_stall_k                      : stall to producer k
//   flush_k/flush_id_k               : flush pulse and id from producer k
//   in_stall                         : downstream stall
//   out_valid/out_address/out_id     : arbitrated request (registered)
//   out_flush/out_flush_id           : forwarded flush pulse (registered)
//   flush_overflow                   : sticky, a flush was dropped
//
// Handshake: a request moves across an interface at a rising edge when its
// valid is high and the stall driven back toward it is low at that edge
// (in_valid_k & ~out_stall_k upstream, out_valid & ~in_stall downstream).
// Valid never depends on the stall of the same interface. Flushes are pulses
// with no handshake.
module req_arbiter_2to1
  import req_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int ID_W   = ID_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ID_W-1:0]   in_id_1,
  input  logic              in_valid_2,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic [ID_W-1:0]   in_id_2,
  output logic              out_stall_1,
  output logic              out_stall_2,
  input  logic              flush_1,
  input  logic [ID_W-1:0]   flush_id_1,
  input  logic              flush_2,
  input  logic [ID_W-1:0]   flush_id_2,
  input  logic              in_stall,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_address,
  output logic [ID_W-1:0]   out_id,
  output logic              out_flush,
  output logic [ID_W-1:0]   out_flush_id,
  output logic              flush_overflow
);

  // Channel-indexed views of the two producer ports (index 0 = channel 1).
  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_address [2];
  logic [ID_W-1:0]   in_id      [2];

  logic [1:0]        hold_valid;
  logic [ADDR_W-1:0] hold_address [2];
  logic [ID_W-1:0]   hold_id      [2];

  logic [1:0] kill_hold;
  logic [1:0] kill_in;
  logic [1:0] cand;
  logic [1:0] grant;
  logic [1:0] stall;
  logic [1:0] take;
  logic       kill_out;
  logic       out_load;
  logic       last_grant_2;  // 1: channel 2 won the most recent grant

  assign in_valid      = {in_valid_2, in_valid_1};
  assign in_address[0] = in_address_1;
  assign in_address[1] = in_address_2;
  assign in_id[0]      = in_id_1;
  assign in_id[1]      = in_id_2;

  function automatic logic id_hit(input logic [ID_W-1:0] id,
                                  input logic            f1,
                                  input logic [ID_W-1:0] fid1,
                                  input logic            f2,
                                  input logic [ID_W-1:0] fid2);
    return (f1 && (id == fid1)) || (f2 && (id == fid2));
  endfunction

  always_comb begin
    kill_hold = '0;
    kill_in   = '0;
    cand      = '0;
    for (int k = 0; k < 2; k++) begin
      kill_hold[k] = hold_valid[k] &
                     id_hit(hold_id[k], flush_1, flush_id_1, flush_2, flush_id_2);
      kill_in[k]   = id_hit(in_id[k], flush_1, flush_id_1, flush_2, flush_id_2);
      cand[k]      = hold_valid[k] & ~kill_hold[k];
    end
  end

  assign kill_out = out_valid & id_hit(out_id, flush_1, flush_id_1, flush_2, flush_id_2);
  assign out_load = ~out_valid | ~in_stall;

  // On a tie the channel that did not win last time is granted.
  assign grant[0] = out_load & cand[0] & (~cand[1] | last_grant_2);
  assign grant[1] = out_load & cand[1] & (~cand[0] | ~last_grant_2);

  // A killed, ungranted hold still reports stall this cycle; it empties at the edge.
  always_comb begin
    stall = '0;
    take  = '0;
    for (int k = 0; k < 2; k++) begin
      stall[k] = hold_valid[k] & ~grant[k];
      take[k]  = in_valid[k] & ~stall[k];
    end
  end

  assign out_stall_1 = stall[0];
  assign out_stall_2 = stall[1];

  // Hold registers. A killed incoming request is still consumed, it just
  // never becomes valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= '0;
      for (int k = 0; k < 2; k++) begin
        hold_address[k] <= '0;
        hold_id[k]      <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (take[k]) begin
          hold_valid[k]   <= ~kill_in[k];
          hold_address[k] <= in_address[k];
          hold_id[k]      <= in_id[k];
        end else if (grant[k] | kill_hold[k]) begin
          hold_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Output stage and round-robin pointer. While stalled the contents are
  // frozen, but a matching flush still invalidates the entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_address  <= '0;
      out_id       <= '0;
      last_grant_2 <= 1'b1;
    end else if (out_load) begin
      if (grant[0]) begin
        out_valid    <= 1'b1;
        out_address  <= hold_address[0];
        out_id       <= hold_id[0];
        last_grant_2 <= 1'b0;
      end else if (grant[1]) begin
        out_valid    <= 1'b1;
        out_address  <= hold_address[1];
        out_id       <= hold_id[1];
        last_grant_2 <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (kill_out) begin
      out_valid <= 1'b0;
    end
  end

  flush_fifo2 #(
    .W (ID_W)
  ) u_flush_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_1    (flush_1),
    .push_id_1 (flush_id_1),
    .push_2    (flush_2),
    .push_id_2 (flush_id_2),
    .pop_valid (out_flush),
    .pop_id    (out_flush_id),
    .overflow  (flush_overflow)
  );

endmodule

// File: tb/tb_req_arbiter_2to1.sv
// Testbench for req_arbiter_2to1: directed scenarios followed by randomized
// traffic, checked cycle by cycle against a transaction-level reference model.
module tb_req_arbiter_2to1;
  import req_arbiter_2to1_pkg::*;

  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = ID_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid_1, in_valid_2;
  logic [AW-1:0] in_address_1, in_address_2;
  logic [IW-1:0] in_id_1, in_id_2;
  logic          out_stall_1, out_stall_2;
  logic          flush_1, flush_2;
  logic [IW-1:0] flush_id_1, flush_id_2;
  logic          in_stall;
  logic          out_valid;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_flush;
  logic [IW-1:0] out_flush_id;
  logic          flush_overflow;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  req_arbiter_2to1 dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid_1     (in_valid_1),
    .in_address_1   (in_address_1),
    .in_id_1        (in_id_1),
    .in_valid_2     (in_valid_2),
    .in_address_2   (in_address_2),
    .in_id_2        (in_id_2),
    .out_stall_1    (out_stall_1),
    .out_stall_2    (out_stall_2),
    .flush_1        (flush_1),
    .flush_id_1     (flush_id_1),
    .flush_2        (flush_2),
    .flush_id_2     (flush_id_2),
    .in_stall       (in_stall),
    .out_valid      (out_valid),
    .out_address    (out_address),
    .out_id         (out_id),
    .out_flush      (out_flush),
    .out_flush_id   (out_flush_id),
    .flush_overflow (flush_overflow)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]   cyc;
    logic          chk_data;
    logic          ov;
    logic [AW-1:0] oa;
    logic [IW-1:0] oid;
    logic          s1;
    logic          s2;
    logic          fl;
    logic [IW-1:0] fid;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  // ---------------- reference model ----------------
  logic          m_hv  [2];
  logic [IW-1:0] m_hid [2];
  logic [AW-1:0] m_ha  [2];
  logic          m_acc [2];
  logic          m_ov;
  logic [IW-1:0] m_oid;
  logic [AW-1:0] m_oa;
  int            m_last;
  logic [IW-1:0] m_fq[$];
  logic          m_fl;
  logic [IW-1:0] m_fid;
  logic          m_ovf;

  // producer state
  logic          p_v  [2];
  logic [IW-1:0] p_id [2];
  logic [AW-1:0] p_a  [2];

  function automatic logic hit(input logic [IW-1:0] id);
    return (flush_1 && id == flush_id_1) || (flush_2 && id == flush_id_2);
  endfunction

  // Records the outputs expected during the current cycle, then advances the
  // model across the coming clock edge.
  task automatic model_step();
    logic          load;
    logic          cand [2];
    logic          stl  [2];
    logic          in_v [2];
    logic [IW-1:0] in_i [2];
    logic [AW-1:0] in_a [2];
    int            win;
    exp_t          e;
    in_v[0] = in_valid_1; in_i[0] = in_id_1; in_a[0] = in_address_1;
    in_v[1] = in_valid_2; in_i[1] = in_id_2; in_a[1] = in_address_2;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_hv[i] = 1'b0; m_hid[i] = '0; m_ha[i] = '0;
      end
      m_ov = 1'b0; m_oid = '0; m_oa = '0; m_last = 2;
      m_fq.delete(); m_fl = 1'b0; m_fid = '0; m_ovf = 1'b0;
    end
    load = !m_ov || !in_stall;
    for (int i = 0; i < 2; i++) cand[i] = m_hv[i] && !hit(m_hid[i]);
    win = 0;
    if (load) begin
      if (cand[0] && cand[1]) win = (m_last == 1) ? 2 : 1;
      else if (cand[0])       win = 1;
      else if (cand[1])       win = 2;
    end
    for (int i = 0; i < 2; i++) stl[i] = m_hv[i] && (win != i + 1);

    e.cyc      = 32'(cyc_cnt);
    e.chk_data = !reset || m_ov;
    e.ov       = m_ov;
    e.oa       = m_oa;
    e.oid      = m_oid;
    e.s1       = stl[0];
    e.s2       = stl[1];
    e.fl       = m_fl;
    e.fid      = m_fid;
    e.ovf      = m_ovf;
    exp_q.push_back(e);

    for (int i = 0; i < 2; i++) m_acc[i] = 1'b0;
    if (reset) begin
      if (load) begin
        if (win != 0) begin
          m_ov = 1'b1; m_oid = m_hid[win-1]; m_oa = m_ha[win-1]; m_last = win;
        end else begin
          m_ov = 1'b0;
        end
      end else if (m_ov && hit(m_oid)) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (in_v[i] && !stl[i]) begin
          m_acc[i] = 1'b1;
          m_hv[i]  = !hit(in_i[i]);
          m_hid[i] = in_i[i];
          m_ha[i]  = in_a[i];
        end else if (win == i + 1 || (m_hv[i] && hit(m_hid[i]))) begin
          m_hv[i] = 1'b0;
        end
      end
      if (flush_1) begin
        if (m_fq.size() < 2) m_fq.push_back(flush_id_1); else m_ovf = 1'b1;
      end
      if (flush_2) begin
        if (m_fq.size() < 2) m_fq.push_back(flush_id_2); else m_ovf = 1'b1;
      end
      if (m_fq.size() > 0) begin
        m_fl = 1'b1; m_fid = m_fq.pop_front();
      end else begin
        m_fl = 1'b0; m_fid = '0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++; errors++;
          $display("FAIL no_expectation cyc=%0d", cyc_cnt);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != 32'(cyc_cnt) || out_valid !== e.ov ||
            out_stall_1 !== e.s1 || out_stall_2 !== e.s2 ||
            out_flush !== e.fl || out_flush_id !== e.fid ||
            flush_overflow !== e.ovf ||
            (e.chk_data && (out_id !== e.oid || out_address !== e.oa))) begin
          errors++;
          $display("FAIL outputs cyc=%0d got v=%b id=%h addr=%h stall=%b%b fl=%b fid=%h ovf=%b required cyc=%0d v=%b id=%h addr=%h stall=%b%b fl=%b fid=%h ovf=%b",
                   cyc_cnt, out_valid, out_id, out_address, out_stall_1, out_stall_2,
                   out_flush, out_flush_id, flush_overflow,
                   e.cyc, e.ov, e.oid, e.oa, e.s1, e.s2, e.fl, e.fid, e.ovf);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] pick_id();
    case ($urandom_range(0, 4))
      0:       return m_hid[0];
      1:       return m_hid[1];
      2:       return m_oid;
      3:       return p_id[$urandom_range(0, 1)];
      default: return IW'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic randomize_cycle();
    in_stall = ($urandom_range(0, 99) < 35);
    for (int i = 0; i < 2; i++) begin
      if (!p_v[i]) p_v[i] = ($urandom_range(0, 99) < 70);
    end
    flush_1    = ($urandom_range(0, 99) < 12);
    flush_id_1 = pick_id();
    flush_2    = ($urandom_range(0, 99) < 12);
    flush_id_2 = pick_id();
  endtask

  // smode: 0 = no stall, 1 = stall held, 2 = fully random traffic
  task automatic stream(input int n, input int en1, input int en2, input int smode);
    for (int c = 0; c < n; c++) begin
      if (smode == 2) begin
        randomize_cycle();
      end else begin
        p_v[0]   = (en1 != 0);
        p_v[1]   = (en2 != 0);
        in_stall = (smode == 1);
        flush_1  = 1'b0;
        flush_2  = 1'b0;
      end
      in_valid_1 = p_v[0]; in_id_1 = p_id[0]; in_address_1 = p_a[0];
      in_valid_2 = p_v[1]; in_id_2 = p_id[1]; in_address_2 = p_a[1];
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i]) begin
          if (smode == 2) begin
            p_id[i] = IW'({(i == 0) ? 4'h1 : 4'h2, 4'($urandom_range(0, 15))});
            p_v[i]  = 1'b0;
          end else begin
            p_id[i] = IW'(p_id[i] + 1'b1);
          end
          p_a[i] = AW'($urandom());
        end
      end
    end
  endtask

  task automatic flush_cycle(input logic f1, input logic [IW-1:0] id1,
                             input logic f2, input logic [IW-1:0] id2,
                             input logic st);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    in_stall   = st;
    flush_1    = f1; flush_id_1 = id1;
    flush_2    = f2; flush_id_2 = id2;
    cyc();
    flush_1 = 1'b0;
    flush_2 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    in_valid_1 = 1'b0; in_address_1 = '0; in_id_1 = '0;
    in_valid_2 = 1'b0; in_address_2 = '0; in_id_2 = '0;
    flush_1 = 1'b0; flush_id_1 = '0; flush_2 = 1'b0; flush_id_2 = '0;
    in_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_a[i] = AW'($urandom());
    end
    p_id[0] = 8'h11;
    p_id[1] = 8'h21;
    @(posedge clk);
    #1;

    // reset state
    stream(2, 0, 0, 0);
    reset = 1'b1;

    // channel 1 alone, streaming
    p_id[0] = 8'h11;
    stream(6, 1, 0, 0);
    stream(3, 0, 0, 0);

    // both channels, alternating grants
    p_id[0] = 8'h11;
    p_id[1] = 8'h21;
    stream(8, 1, 1, 0);

    // downstream stall with both holds full, then release
    stream(5, 1, 1, 1);
    stream(6, 1, 1, 0);
    stream(4, 0, 0, 0);

    // flush of a stalled output entry
    p_id[0] = 8'h19;
    stream(1, 1, 0, 1);
    stream(1, 0, 0, 1);
    flush_cycle(1'b1, 8'h19, 1'b0, 8'h00, 1'b1);
    stream(3, 0, 0, 0);

    // two flushes in one cycle are forwarded in channel order
    flush_cycle(1'b1, 8'h19, 1'b1, 8'h25, 1'b0);
    stream(3, 0, 0, 0);

    // flush queue overflow is sticky until reset
    flush_cycle(1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
    flush_cycle(1'b1, 8'h33, 1'b1, 8'h34, 1'b0);
    stream(5, 0, 0, 0);
    reset = 1'b0;
    stream(1, 0, 0, 0);
    reset = 1'b1;
    stream(2, 0, 0, 0);

    // random traffic with a reset in the middle
    stream(700, 0, 0, 2);
    reset = 1'b0;
    stream(2, 0, 0, 2);
    reset = 1'b1;
    stream(800, 0, 0, 2);
    stream(4, 0, 0, 0);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
